ssd_cmd_scheduler: RTL
======================

SSD_CMD_SCHEDULER -- requirements
Module: ssd_cmd_scheduler

Interface
REQ-001 Parameter WR_BURST_MAX, default 4: max consecutive write grants while a read is pending (1..15).
REQ-002 Parameter TIMEOUT_CYC, default 1048576: max WAIT_DONE cycles before fault (24-bit).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 nReset  in  1  synchronous, active-low reset.
REQ-005 rd_cmd_data  in  45  read command {lba, sectorcnt, num_words} packed as for the command adapter.
REQ-006 rd_cmd_valid / rd_cmd_ready  in / out  1  read command handshake.
REQ-007 wr_cmd_data  in  45  write command, same packing.
REQ-008 wr_cmd_valid / wr_cmd_ready  in / out  1  write command handshake.
REQ-009 out_cmd_data  out  46  {cmd45, is_write}; bit0=1 write, 0 read.
REQ-010 out_cmd_valid / out_cmd_ready  out / in  1  handshake to command adapter.
REQ-011 cmd_success, cmd_failed  in  1  single-cycle completion pulses from HBA.
REQ-012 link_initialized  in  1  SATA link up; no grant while low.
REQ-013 busy  out  1  high in any state except IDLE.
REQ-014 timeout_err  out  1  sticky fault flag.
REQ-015 fail_cnt  out  16  count of cmd_failed pulses, wraps.
REQ-016 state_de  out  2  current state for debug.

Function
REQ-017 States: IDLE=0, ISSUE=1, WAIT_DONE=2, FAULT=3.
REQ-018 IDLE: if link_initialized and any valid, grant one requester, pulse its ready for exactly that cycle, register data into out_cmd_data, go ISSUE.
REQ-019 Arbitration: write wins unless wr_streak==WR_BURST_MAX and rd_cmd_valid, then read wins; read-only or write-only requests granted directly.
REQ-020 wr_streak (4-bit): +1 on write grant, cleared on read grant, saturates at WR_BURST_MAX.
REQ-021 rd_cmd_ready and wr_cmd_ready never both high; both low outside IDLE grant cycle.
REQ-022 ISSUE: out_cmd_valid=1, out_cmd_data stable; on out_cmd_ready go WAIT_DONE next cycle with out_cmd_valid=0.
REQ-023 Exactly one command outstanding; no grant until completion.
REQ-024 WAIT_DONE: cmd_success or cmd_failed -> IDLE next cycle; cmd_failed also increments fail_cnt; both same cycle counts as failed.
REQ-025 Timer cleared on WAIT_DONE entry, +1 per cycle; at TIMEOUT_CYC-1 without completion -> FAULT, timeout_err=1.
REQ-026 Completion pulses outside WAIT_DONE ignored (no state change, no fail_cnt change).
REQ-027 FAULT: absorbing until reset; no grants, out_cmd_valid=0, busy=1.
REQ-028 link_initialized falling in ISSUE/WAIT_DONE does not abort; only blocks new grants.
REQ-029 Grant-to-out_cmd_valid latency: 1 cycle.

Reset
REQ-030 On nReset=0 at clk edge: state IDLE, out_cmd_valid 0, out_cmd_data 0, both readies 0, wr_streak 0, timer 0, fail_cnt 0, timeout_err 0, busy 0.
REQ-031 Reset mid-ISSUE/WAIT_DONE discards the command; no replay.

Structure
REQ-032 State encodings, CMD_W=45 and is_write bit position in shared package mcd_ssd_pkg.
REQ-033 Single module; optional sub-module ssd_cmd_arb (combinational 2-way streak arbiter).

Verification
REQ-034 Reset, link_initialized=1, only read valid, out_cmd_ready=1 -> rd_cmd_ready pulse, out_cmd_data[0]=0 next cycle, cmd_success after 10 cycles -> IDLE.
REQ-035 Read and write valid continuously, WR_BURST_MAX=4, immediate completions -> grant order W,W,W,W,R,W,W,W,W,R.
REQ-036 out_cmd_ready held low 20 cycles in ISSUE -> out_cmd_valid high and data stable 20 cycles; no new ready pulses.
REQ-037 TIMEOUT_CYC=100, no completion -> FAULT and timeout_err=1 exactly 100 cycles after WAIT_DONE entry; further valids never granted.
REQ-038 Three completions with cmd_failed, one with cmd_success and cmd_failed together, plus a stray cmd_failed in IDLE -> fail_cnt=4.
REQ-039 link_initialized=0 with both valids high 50 cycles -> no ready, busy=0; raise it -> write granted next cycle.

Source files
------------

// File: rtl/mcd_ssd_pkg.sv
// Shared definitions for the SSD command path: command widths, flag position, scheduler states.
// Latency: none (definitions only).
// Backpressure: not applicable.
package mcd_ssd_pkg;

    // {lba, sectorcnt, num_words} as packed for the command adapter
    localparam int CMD_W     = 45;
    // Scheduler output word is {cmd, is_write}
    localparam int OUT_W     = CMD_W + 1;
    localparam int IS_WR_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_FAULT     = 2'd3
    } sched_state_t;

endpackage

// File: rtl/ssd_cmd_arb.sv
// Two-way read/write arbiter: writes win until WR_BURST_MAX back-to-back write grants, then a waiting read wins.
// Latency: combinational.
// Backpressure: grants only while en is high; losing requester simply stays pending.
module ssd_cmd_arb #(
    parameter int WR_BURST_MAX = 4
) (
    input  logic       en,
    input  logic       rd_valid,
    input  logic       wr_valid,
    input  logic [3:0] wr_streak,
    output logic       grant_rd,
    output logic       grant_wr
);

    logic rd_turn;

    // Read goes when it is alone or when the write burst allowance is used up
    always_comb begin
        rd_turn  = rd_valid && (!wr_valid || (wr_streak == 4'(WR_BURST_MAX)));
        grant_rd = en && rd_turn;
        grant_wr = en && wr_valid && !rd_turn;
    end

endmodule

// File: rtl/ssd_cmd_scheduler.sv
// Single-outstanding SSD command scheduler: arbitrates read/write commands, issues one, waits for completion or timeout.
// Latency: grant to out_cmd_valid is 1 cycle; completion returns to IDLE the next cycle.
// Backpressure: holds out_cmd_valid/data until out_cmd_ready; no new grant until the outstanding command completes.
module ssd_cmd_scheduler
    import mcd_ssd_pkg::*;
#(
    parameter int WR_BURST_MAX = 4,
    parameter int TIMEOUT_CYC  = 1048576
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [CMD_W-1:0] rd_cmd_data,
    input  logic             rd_cmd_valid,
    output logic             rd_cmd_ready,
    input  logic [CMD_W-1:0] wr_cmd_data,
    input  logic             wr_cmd_valid,
    output logic             wr_cmd_ready,
    output logic [OUT_W-1:0] out_cmd_data,
    output logic             out_cmd_valid,
    input  logic             out_cmd_ready,
    input  logic             cmd_success,
    input  logic             cmd_failed,
    input  logic             link_initialized,
    output logic             busy,
    output logic             timeout_err,
    output logic [15:0]      fail_cnt,
    output logic [1:0]       state_de
);

    localparam logic [23:0] TMO_LAST   = 24'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  STREAK_MAX = 4'(WR_BURST_MAX);

    sched_state_t state, state_nxt;
    logic [3:0]   wr_streak;
    logic [23:0]  timer;
    logic         grant_en, grant_rd, grant_wr, done;

    // Grants only from IDLE with the link up; masked while reset is asserted
    assign grant_en = (state == ST_IDLE) && link_initialized && nReset;
    assign done     = cmd_success || cmd_failed;

    ssd_cmd_arb #(
        .WR_BURST_MAX (WR_BURST_MAX)
    ) u_arb (
        .en        (grant_en),
        .rd_valid  (rd_cmd_valid),
        .wr_valid  (wr_cmd_valid),
        .wr_streak (wr_streak),
        .grant_rd  (grant_rd),
        .grant_wr  (grant_wr)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!nReset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state: grant, hand-off, completion or timeout; FAULT is absorbing
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (grant_rd || grant_wr) state_nxt = ST_ISSUE;
            ST_ISSUE:     if (out_cmd_ready)       state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (done)                   state_nxt = ST_IDLE;
                else if (timer == TMO_LAST) state_nxt = ST_FAULT;
            end
            default:                               state_nxt = ST_FAULT;
        endcase
    end

    // Outputs decoded from state and the current grant
    always_comb begin
        busy          = (state != ST_IDLE);
        out_cmd_valid = (state == ST_ISSUE);
        state_de      = state;
        rd_cmd_ready  = grant_rd;
        wr_cmd_ready  = grant_wr;
    end

    // Datapath: command capture, write streak, completion timer, fault and failure bookkeeping
    always_ff @(posedge clk) begin
        if (!nReset) begin
            out_cmd_data <= '0;
            wr_streak    <= '0;
            timer        <= '0;
            fail_cnt     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if (grant_wr) begin
                out_cmd_data <= {wr_cmd_data, 1'b1};
                if (wr_streak != STREAK_MAX) wr_streak <= wr_streak + 4'd1;
            end else if (grant_rd) begin
                out_cmd_data <= {rd_cmd_data, 1'b0};
                wr_streak    <= '0;
            end

            if (state == ST_ISSUE && out_cmd_ready) timer <= '0;
            else if (state == ST_WAIT_DONE)         timer <= timer + 24'd1;

            if (state == ST_WAIT_DONE && cmd_failed) fail_cnt <= fail_cnt + 16'd1;

            if (state == ST_WAIT_DONE && !done && timer == TMO_LAST) timeout_err <= 1'b1;
        end
    end

endmodule
